// File: rtl/wb_bram_resp_pkg.sv
// Shared definitions for the Wishbone block-RAM responder: FSM states and
// Wishbone cycle-type codes.
package wb_bram_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACK   = 2'd2,
    BURST = 2'd3
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Only the incrementing-burst code keeps a burst alive; every other code,
  // including reserved ones, behaves like classic or end-of-burst.
  function automatic logic cti_is_incr(input logic [2:0] cti);
    return (cti == CTI_INCR) && (cti != CTI_CLASSIC) && (cti != CTI_EOB);
  endfunction

endpackage

// File: rtl/wb_bram_resp_mem.sv
// Byte-enabled single-port RAM with a registered read port and no reset.
module wb_bram_resp_mem #(
  parameter int AW = 11
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [3:0]    sel_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [0:(1<<AW)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_bram_resp.sv
// Wishbone B3 slave backed by a block RAM: classic cycles with optional
// wait states, and single-beat-per-cycle incrementing bursts.
module wb_bram_resp
  import wb_bram_resp_pkg::*;
#(
  parameter int adr_width   = 11,
  parameter int wait_states = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic [1:0]  dbg_state_o
);

  localparam logic [2:0] WAIT_LAST = 3'((wait_states > 0) ? wait_states - 1 : 0);
  localparam logic [adr_width-1:0] ADDR_ONE = {{(adr_width-1){1'b0}}, 1'b1};

  // Handshake: a beat completes in any cycle where cyc, stb and ack are all
  // high; ack is a pure combinational function of the current request and state.
  state_t               state_q, state_d;
  logic [adr_width-1:0] addr_q, addr_d;
  logic [2:0]           wcnt_q, wcnt_d;
  logic                 req, beat, mem_we;
  logic [adr_width-1:0] mem_addr;
  logic [31:0]          mem_rdata;
  logic                 unused_adr_bits;

  assign unused_adr_bits = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};

  assign req      = wb_cyc_i & wb_stb_i;
  assign beat     = req & ((state_q == ACK) || (state_q == BURST));
  assign mem_we   = beat & wb_we_i;
  // Writes target the current beat; otherwise prefetch the next address so
  // burst data is ready one cycle later.
  assign mem_addr = mem_we ? addr_q : addr_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = wb_adr_i[adr_width+1:2];
          wcnt_d  = '0;
          state_d = (wait_states > 0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == WAIT_LAST) begin
          state_d = ACK;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      ACK: begin
        if (req && cti_is_incr(wb_cti_i)) begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = BURST;
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (wb_stb_i) begin
          addr_d = addr_q + ADDR_ONE;
          if (!cti_is_incr(wb_cti_i)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
    end
  end

  wb_bram_resp_mem #(
    .AW(adr_width)
  ) u_mem (
    .clk_i   (sys_clk),
    .addr_i  (mem_addr),
    .we_i    (mem_we),
    .sel_i   (wb_sel_i),
    .wdata_i (wb_dat_i),
    .rdata_o (mem_rdata)
  );

  assign wb_ack_o    = beat;
  assign wb_dat_o    = beat ? mem_rdata : 32'h0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_bram_resp.sv
// Randomized bench for wb_bram_resp: two instances (0 and 3 wait states)
// checked against a word-array memory model and protocol timing rules.
module tb_wb_bram_resp;
  import wb_bram_resp_pkg::*;

  logic        clk, rst_n;
  logic [31:0] adr, dat;
  logic [2:0]  cti;
  logic [3:0]  sel;
  logic        we, cyc0, cyc3, stb;
  logic        ack0, ack3;
  logic [31:0] dat0, dat3;
  logic [1:0]  st0, st3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ref_mem [2][2048];
  logic [31:0] bdat [8];
  logic [2:0]  classic_ctis [5] = '{3'b000, 3'b111, 3'b001, 3'b011, 3'b100};
  logic [31:0] pool [8];

  wb_bram_resp #(.adr_width(11), .wait_states(0)) dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .wb_adr_i(adr), .wb_cti_i(cti),
    .wb_sel_i(sel), .wb_dat_i(dat), .wb_dat_o(dat0), .wb_we_i(we),
    .wb_cyc_i(cyc0), .wb_stb_i(stb), .wb_ack_o(ack0), .dbg_state_o(st0));

  wb_bram_resp #(.adr_width(11), .wait_states(3)) dut3 (
    .sys_clk(clk), .sys_rst_n(rst_n), .wb_adr_i(adr), .wb_cti_i(cti),
    .wb_sel_i(sel), .wb_dat_i(dat), .wb_dat_o(dat3), .wb_we_i(we),
    .wb_cyc_i(cyc3), .wb_stb_i(stb), .wb_ack_o(ack3), .dbg_state_o(st3));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic cur_ack(input int d);
    return (d == 0) ? ack0 : ack3;
  endfunction
  function automatic logic [31:0] cur_dat(input int d);
    return (d == 0) ? dat0 : dat3;
  endfunction
  function automatic logic [31:0] cur_st(input int d);
    return {30'b0, ((d == 0) ? st0 : st3)};
  endfunction
  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic set_cyc(input int d, input logic v);
    if (d == 0) cyc0 = v; else cyc3 = v;
  endtask

  function automatic void model_write(input int d, input logic [10:0] w,
                                      input logic [31:0] data, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[d][w][8*b +: 8] = data[8*b +: 8];
  endfunction

  // driver: one classic cycle, stb held one cycle past ack to prove ack is single
  task automatic classic(input int d, input logic [31:0] a, input logic w_en,
                         input logic [31:0] data, input logic [3:0] s);
    int lat;
    logic got;
    @(posedge clk); #1;
    adr = a; we = w_en; dat = data; sel = s;
    cti = classic_ctis[$urandom_range(0, 4)];
    set_cyc(d, 1'b1); stb = 1'b1;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (cur_ack(d)) got = 1'b1; else lat++;
    end
    check("classic_latency", 32'(lat), 32'(1 + ws(d)));
    if (got) begin
      if (w_en) model_write(d, a[12:2], data, s);
      else check("classic_rdata", cur_dat(d), ref_mem[d][a[12:2]]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("classic_single_ack", {31'b0, cur_ack(d)}, 32'd0);
    @(posedge clk); #1;
    set_cyc(d, 1'b0); stb = 1'b0; we = 1'b0;
    @(posedge clk);
  endtask

  // driver: incrementing burst of n beats; abort_after>0 ends it early by
  // dropping cyc (use_rst=0) or by asserting reset (use_rst=1)
  task automatic burst(input int d, input logic [31:0] a, input int n, input logic w_en,
                       input int abort_after, input logic use_rst);
    int lat;
    logic got;
    logic [10:0] w;
    w = a[12:2];
    @(posedge clk); #1;
    adr = a; we = w_en; sel = 4'hf; dat = bdat[0];
    cti = (n > 1) ? CTI_INCR : CTI_EOB;
    set_cyc(d, 1'b1); stb = 1'b1;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (cur_ack(d)) got = 1'b1; else lat++;
    end
    check("burst_latency", 32'(lat), 32'(1 + ws(d)));
    if (!got) begin
      set_cyc(d, 1'b0); stb = 1'b0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(negedge clk);
        check("burst_ack", {31'b0, cur_ack(d)}, 32'd1);
      end
      if (w_en) ref_mem[d][w] = bdat[i];
      else check("burst_rdata", cur_dat(d), ref_mem[d][w]);
      w = w + 11'd1;
      @(posedge clk); #1;
      adr = {19'b0, w, 2'b00};
      dat = bdat[(i + 1) % 8];
      cti = (i + 2 == n) ? CTI_EOB : CTI_INCR;
      if (i + 1 == abort_after) begin
        if (use_rst) begin
          rst_n = 1'b0;
          #1;
          check("rst_ack_low", {31'b0, cur_ack(d)}, 32'd0);
          check("rst_dat_zero", cur_dat(d), 32'd0);
          check("rst_state_idle", cur_st(d), 32'(IDLE));
        end else begin
          set_cyc(d, 1'b0); stb = 1'b0;
          @(negedge clk);
          check("drop_no_ack", {31'b0, cur_ack(d)}, 32'd0);
        end
        @(posedge clk); #1;
        set_cyc(d, 1'b0); stb = 1'b0; we = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        check("abort_state_idle", cur_st(d), 32'(IDLE));
        @(posedge clk);
        return;
      end
    end
    set_cyc(d, 1'b0); stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check("burst_end_idle", cur_st(d), 32'(IDLE));
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] a, x;
    int d, n;
    rst_n = 1'b0; adr = '0; dat = '0; cti = '0; sel = '0; we = 1'b0;
    cyc0 = 1'b1; cyc3 = 1'b1; stb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack0", {31'b0, ack0}, 32'd0);
    check("reset_ack3", {31'b0, ack3}, 32'd0);
    check("reset_dat0", dat0, 32'd0);
    check("reset_state0", {30'b0, st0}, 32'(IDLE));
    check("reset_state3", {30'b0, st3}, 32'(IDLE));
    cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // directed: classic write/read, both latencies
    classic(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'hf);
    classic(0, 32'h10, 1'b0, 32'h0, 4'hf);
    classic(1, 32'h10, 1'b1, 32'hDEADBEEF, 4'hf);
    classic(1, 32'h10, 1'b0, 32'h0, 4'hf);

    // directed: byte-lane merge
    classic(0, 32'h20, 1'b1, 32'hAABBCCDD, 4'hf);
    classic(0, 32'h20, 1'b1, 32'h11223344, 4'b0101);
    check("merge_model", ref_mem[0][8], 32'hAA22CC44);
    classic(0, 32'h20, 1'b0, 32'h0, 4'hf);

    // directed: 4-beat burst read from 0x100 on both instances
    for (int dd = 0; dd < 2; dd++) begin
      for (int i = 0; i < 4; i++) classic(dd, 32'h100 + 32'(4 * i), 1'b1, 32'(i + 1), 4'hf);
      burst(dd, 32'h100, 4, 1'b0, 0, 1'b0);
    end

    // directed: wrap from the last word to word 0
    classic(0, 32'h1FFC, 1'b1, 32'hCAFE0001, 4'hf);
    classic(0, 32'h0000, 1'b1, 32'hCAFE0002, 4'hf);
    burst(0, 32'h1FFC, 2, 1'b0, 0, 1'b0);

    // directed: cyc dropped after 2 of 4 write beats
    for (int i = 0; i < 4; i++) classic(0, 32'h200 + 32'(4 * i), 1'b1, 32'h5000 + 32'(i), 4'hf);
    for (int i = 0; i < 8; i++) bdat[i] = 32'h7700_0000 + 32'(i);
    burst(0, 32'h200, 4, 1'b1, 2, 1'b0);
    for (int i = 0; i < 4; i++) classic(0, 32'h200 + 32'(4 * i), 1'b0, 32'h0, 4'hf);

    // directed: reset mid write burst; the in-flight beat must not land
    for (int i = 0; i < 4; i++) classic(0, 32'h300 + 32'(4 * i), 1'b1, 32'h6000 + 32'(i), 4'hf);
    for (int i = 0; i < 8; i++) bdat[i] = 32'h8800_0000 + 32'(i);
    burst(0, 32'h300, 4, 1'b1, 2, 1'b1);
    for (int i = 0; i < 4; i++) classic(0, 32'h300 + 32'(4 * i), 1'b0, 32'h0, 4'hf);

    // random: full-word preload of a pool, then mixed partial writes and reads
    for (int i = 0; i < 8; i++) begin
      pool[i] = {19'b0, 11'($urandom_range(0, 2047)), 2'b00};
      classic(0, pool[i], 1'b1, $urandom, 4'hf);
      classic(1, pool[i], 1'b1, $urandom, 4'hf);
    end
    for (int i = 0; i < 30; i++) begin
      d = $urandom_range(0, 1);
      a = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 1)
        classic(d, a, 1'b1, $urandom, 4'($urandom_range(1, 15)));
      else
        classic(d, a, 1'b0, 32'h0, 4'hf);
    end

    // random: burst write then burst read back, random start and length
    for (int i = 0; i < 6; i++) begin
      d = $urandom_range(0, 1);
      n = $urandom_range(2, 6);
      a = {19'b0, 11'($urandom_range(2040, 2047)), 2'b00};
      for (int k = 0; k < 8; k++) bdat[k] = $urandom;
      burst(d, a, n, 1'b1, 0, 1'b0);
      burst(d, a, n, 1'b0, 0, 1'b0);
      x = {19'b0, 11'(a[12:2] + 11'(n - 1)), 2'b00};
      classic(d, x, 1'b0, 32'h0, 4'hf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_bram_resp.md
WB_BRAM_RESP -- requirements
Module: wb_bram_resp

Interface
REQ-001 SHALL have parameter adr_width, default 11, meaning log2 of memory depth in 32-bit words.
REQ-002 SHALL have parameter wait_states, default 0, range 0-7, meaning extra cycles inserted before the first ack of each cycle.
REQ-003 SHALL have port sys_clk, input, 1, the single clock; all logic on the rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port wb_adr_i, input, 32, byte address; word index is wb_adr_i[adr_width+1:2], other bits ignored.
REQ-006 SHALL have port wb_cti_i, input, 3, cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst; other codes treated as 000.
REQ-007 SHALL have port wb_sel_i, input, 4, byte-lane enables for writes.
REQ-008 SHALL have port wb_dat_i, input, 32, write data.
REQ-009 SHALL have port wb_dat_o, output, 32, read data, valid whenever wb_ack_o is high.
REQ-010 SHALL have ports wb_we_i, wb_cyc_i and wb_stb_i, input, 1 each, standard Wishbone B3 controls.
REQ-011 SHALL have port wb_ack_o, output, 1, transfer acknowledge.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, ACK and BURST.
REQ-013 IDLE: on cyc&stb SHALL latch the word address into addr_r and present it to the memory; next state is WAIT if wait_states>0, else ACK.
REQ-014 WAIT: SHALL count wait_states cycles, then go to ACK; cyc low SHALL force IDLE.
REQ-015 wb_ack_o SHALL equal cyc & stb & (state==ACK or state==BURST); ack is never high without cyc&stb in the same cycle.
REQ-016 First-ack latency SHALL be 1+wait_states cycles after cyc&stb is first sampled in IDLE.
REQ-017 On every acked beat with we=1, only the byte lanes with sel set SHALL be written at addr_r; unselected bytes are preserved.
REQ-018 ACK: if cti==010 and cyc&stb, SHALL increment addr_r and go to BURST; otherwise SHALL go to IDLE.
REQ-019 BURST: SHALL ack every cycle cyc&stb is high, with no wait states reapplied, and increment addr_r after each acked beat.
REQ-020 Read data for addr_r+1 SHALL be available in the cycle after each burst beat, giving one beat per cycle.
REQ-021 BURST: SHALL exit to IDLE after an acked beat with cti==111 or cti==000.
REQ-022 BURST with stb low and cyc high SHALL hold state and address with no ack.
REQ-023 cyc low in any state SHALL return the FSM to IDLE next cycle, with no write and no ack.
REQ-024 addr_r SHALL wrap from 2^adr_width-1 to 0.
REQ-025 A write beat followed by a read of the same address SHALL return the new data.

Reset
REQ-026 Asserting sys_rst_n low SHALL immediately set state=IDLE, wb_ack_o=0, wait counter=0, addr_r=0 and wb_dat_o=0; memory contents are undefined.
REQ-027 Reset mid-burst SHALL abort the burst; any in-flight beat is not written.

Structure
REQ-028 A shared package SHALL hold the state enumeration and the CTI constants CTI_CLASSIC=000, CTI_INCR=010 and CTI_EOB=111.
REQ-029 Byte-enabled single-port RAM SHALL be a sub-module, wb_bram_resp_mem, with a synchronous read port and no reset.

Verification
REQ-030 Classic write of 0xDEADBEEF to 0x10 with sel=1111, then classic read of 0x10 with wait_states=0 -> ack 1 cycle after stb, dat_o=0xDEADBEEF.
REQ-031 Same read with wait_states=3 -> ack exactly 4 cycles after stb, single-cycle ack.
REQ-032 Burst read of 4 words from 0x100 (cti 010,010,010,111), preloaded 1,2,3,4 -> acks on 4 consecutive cycles, data 1,2,3,4, then IDLE.
REQ-033 Write 0xAABBCCDD to 0x20, then write 0x11223344 with sel=0101, then read -> 0xAA22CC44.
REQ-034 Burst starting at the last word (adr_width=11, addr 0x1FFC) for 2 beats -> second beat accesses word 0.
REQ-035 Drop cyc after 2 of 4 burst write beats -> only 2 words written, no further ack, FSM in IDLE next cycle; also assert sys_rst_n low mid-burst -> ack low immediately.
